thermo_ctrl: RTL and testbench

- Sequential thermostat controller that drives the heater and cooler from 8-bit (parameterised) target and actual temperatures.
- Adds on top of the plain band comparison:
  - hysteresis: run until the target is reached;
  - a minimum run time per activation;
  - a dead-time lockout between any two activations, so heater and cooler never overlap or short-cycle.
- Sits between the temperature sensor/set-point registers and the heater/cooler drive outputs.

---
 rtl/thermo_if.sv | 23 ++
 rtl/thermo_ctrl.sv | 97 +++++++++
 tb/tb_thermo_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/thermo_if.sv
// Thermostat controller bus: set-point/sensor inputs and heater/cooler drive outputs.
// master = set-point/sensor side, slave = controller.
interface thermo_if #(
    parameter int unsigned SIZE = 8
) ();
    logic            en;
    logic [SIZE-1:0] Tset;
    logic [SIZE-1:0] Tact;
    logic            heat;
    logic            cool;
    logic            lockout;
    logic [1:0]      state;

    modport master (
        output en, Tset, Tact,
        input  heat, cool, lockout, state
    );

    modport slave (
        input  en, Tset, Tact,
        output heat, cool, lockout, state
    );
endinterface

// File: rtl/thermo_ctrl.sv
// Thermostat controller: band-triggered heat/cool with hysteresis, minimum run and dead time.
// Minimum-run enforcement is enabled by defining THERMO_MINRUN_EN.
module thermo_ctrl #(
    parameter int unsigned SIZE   = 8,
    parameter int unsigned BAND   = 4,
    parameter int unsigned MINRUN = 16,
    parameter int unsigned DEAD   = 8
) (
    input logic     clk,
    input logic     rst,
    thermo_if.slave bus
);
    localparam int unsigned W      = SIZE + 1;
    localparam int unsigned CntMax = (MINRUN > DEAD) ? MINRUN : DEAD;
    localparam int unsigned CW     = $clog2(CntMax + 1);

    localparam logic [W-1:0]  BandW    = W'(BAND);
    localparam logic [CW-1:0] CntSat   = {CW{1'b1}};
    localparam logic [CW-1:0] DeadLast = CW'(DEAD - 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StHeat = 2'b01,
        StCool = 2'b10,
        StDead = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [W-1:0] tset_w, tact_w;
    logic         heat_req, cool_req, heat_done, cool_done, minrun_met;

    // One extra bit so adding the band can never wrap.
    assign tset_w    = {1'b0, bus.Tset};
    assign tact_w    = {1'b0, bus.Tact};
    assign heat_req  = (tact_w + BandW) < tset_w;
    assign cool_req  = tact_w > (tset_w + BandW);
    assign heat_done = tact_w >= tset_w;
    assign cool_done = tact_w <= tset_w;

`ifdef THERMO_MINRUN_EN
    localparam logic [CW-1:0] MinrunLast = CW'(MINRUN - 1);
    assign minrun_met = (cnt_q >= MinrunLast);
`else
    assign minrun_met = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (bus.en && heat_req) begin
                    state_d = StHeat;
                end else if (bus.en && cool_req) begin
                    state_d = StCool;
                end
            end
            StHeat: begin
                if (!bus.en || (heat_done && minrun_met)) state_d = StDead;
            end
            StCool: begin
                if (!bus.en || (cool_done && minrun_met)) state_d = StDead;
            end
            StDead: begin
                if (cnt_q == DeadLast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Counter restarts on every transition so each state times itself from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != StIdle && cnt_q != CntSat) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        bus.heat    = (state_q == StHeat);
        bus.cool    = (state_q == StCool);
        bus.lockout = (state_q == StDead);
        bus.state   = state_q;
    end
endmodule

// File: tb/tb_thermo_ctrl.sv
// Self-checking bench for thermo_ctrl: vector table, hand-written corner sequences,
// and randomized stimulus against a cycle-count reference model.
module tb_thermo_ctrl;
    localparam int unsigned SIZE   = 8;
    localparam int unsigned BAND   = 4;
    localparam int unsigned MINRUN = 16;
    localparam int unsigned DEAD   = 8;
`ifdef THERMO_MINRUN_EN
    localparam int EXP_RUN = 16;
`else
    localparam int EXP_RUN = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    thermo_if #(.SIZE(SIZE)) bus ();

    thermo_ctrl #(
        .SIZE  (SIZE),
        .BAND  (BAND),
        .MINRUN(MINRUN),
        .DEAD  (DEAD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 idle, 1 heat, 2 cool, 3 dead; spent = full cycles already in mode.
    int m_mode  = 0;
    int m_spent = 0;

    typedef struct {
        bit    r;
        bit    e;
        int    tset;
        int    tact;
        int    st;
        string name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int enc(input int st);
        return (st << 3) | ((st == 1) ? 4 : 0) | ((st == 2) ? 2 : 0) | ((st == 3) ? 1 : 0);
    endfunction

    function automatic int observed();
        return int'({bus.state, bus.heat, bus.cool, bus.lockout});
    endfunction

    task automatic model_step(input bit r, input bit e, input int ts, input int ta);
        bit hreq, creq, hdone, cdone, long_enough;
        int done_cycles;
        hreq  = (ta + int'(BAND)) < ts;
        creq  = ta > (ts + int'(BAND));
        hdone = ta >= ts;
        cdone = ta <= ts;
        done_cycles = m_spent + 1;
`ifdef THERMO_MINRUN_EN
        long_enough = done_cycles >= int'(MINRUN);
`else
        long_enough = 1'b1;
`endif
        if (r) begin
            m_mode = 0; m_spent = 0;
        end else if (m_mode == 0) begin
            if (e && hreq) begin
                m_mode = 1; m_spent = 0;
            end else if (e && creq) begin
                m_mode = 2; m_spent = 0;
            end
        end else if (m_mode == 1 || m_mode == 2) begin
            if (!e || (((m_mode == 1) ? hdone : cdone) && long_enough)) begin
                m_mode = 3; m_spent = 0;
            end else begin
                m_spent = done_cycles;
            end
        end else begin
            if (done_cycles >= int'(DEAD)) begin
                m_mode = 0; m_spent = 0;
            end else begin
                m_spent = done_cycles;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rst, bus.en, int'(bus.Tset), int'(bus.Tact));
        @(negedge clk);
    endtask

    task automatic set_in(input bit r, input bit e, input int ts, input int ta);
        rst      = r;
        bus.en   = e;
        bus.Tset = SIZE'(ts);
        bus.Tact = SIZE'(ta);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int hc, lc, ov, ts, ta;
        set_in(1'b1, 1'b1, 0, 0);

        vecs.push_back('{1'b1, 1'b1, 20, 10, 0, "reset_hold0"});
        vecs.push_back('{1'b1, 1'b1, 20, 10, 0, "reset_hold1"});
        vecs.push_back('{1'b0, 1'b1, 20, 10, 1, "reset_release_heat"});
        vecs.push_back('{1'b1, 1'b1, 20, 16, 0, "band_heat_rst"});
        vecs.push_back('{1'b0, 1'b1, 20, 16, 0, "band_heat_edge_idle"});
        vecs.push_back('{1'b0, 1'b1, 20, 15, 1, "band_heat_enter"});
        vecs.push_back('{1'b1, 1'b1, 20, 24, 0, "band_cool_rst"});
        vecs.push_back('{1'b0, 1'b1, 20, 24, 0, "band_cool_edge_idle"});
        vecs.push_back('{1'b0, 1'b1, 20, 25, 2, "band_cool_enter"});
        vecs.push_back('{1'b1, 1'b1, 253, 255, 0, "ovf_rst0"});
        vecs.push_back('{1'b0, 1'b1, 253, 255, 0, "ovf_253_255_idle"});
        vecs.push_back('{1'b1, 1'b1, 2, 255, 0, "ovf_rst1"});
        vecs.push_back('{1'b0, 1'b1, 2, 255, 2, "ovf_2_255_cool"});
        vecs.push_back('{1'b1, 1'b1, 255, 0, 0, "ovf_rst2"});
        vecs.push_back('{1'b0, 1'b1, 255, 0, 1, "ovf_255_0_heat"});
        vecs.push_back('{1'b1, 1'b0, 255, 0, 0, "en_off_rst"});
        vecs.push_back('{1'b0, 1'b0, 255, 0, 0, "en_off_no_start"});

        foreach (vecs[i]) begin
            set_in(vecs[i].r, vecs[i].e, vecs[i].tset, vecs[i].tact);
            tick();
            check(vecs[i].name, observed(), enc(vecs[i].st));
        end

        // Minimum run then exactly DEAD cycles of lockout.
        set_in(1'b1, 1'b1, 20, 10);
        tick();
        rst = 1'b0;
        tick();
        check("minrun_heat_on", int'(bus.heat), 1);
        tick();
        tick();
        bus.Tact = 8'd20;
        hc = 3;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!bus.heat) break;
            hc++;
        end
        check("minrun_heat_cycles", hc, EXP_RUN);
        lc = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.lockout) break;
            lc++;
            tick();
        end
        check("minrun_lockout_cycles", lc, int'(DEAD));
        check("minrun_back_idle", observed(), enc(0));

        // Reversal: cool -> dead -> one idle cycle -> heat.
        set_in(1'b1, 1'b1, 20, 30);
        tick();
        rst = 1'b0;
        tick();
        check("rev_cool_on", observed(), enc(2));
        for (int i = 1; i < int'(MINRUN); i++) tick();
        check("rev_cool_held", observed(), enc(2));
        bus.Tact = 8'd5;
        tick();
        lc = 0;
        ov = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.heat && bus.cool) ov++;
            if (!bus.lockout) break;
            if (bus.heat) ov++;
            lc++;
            tick();
        end
        check("rev_dead_cycles", lc, int'(DEAD));
        check("rev_no_overlap", ov, 0);
        check("rev_idle_gap", observed(), enc(0));
        tick();
        check("rev_heat_on", observed(), enc(1));

        // Abort by en, then reset in the middle of dead time.
        set_in(1'b1, 1'b1, 20, 10);
        tick();
        rst = 1'b0;
        tick();
        tick();
        bus.en = 1'b0;
        tick();
        check("abort_en_dead", observed(), enc(3));
        bus.en = 1'b1;
        tick();
        tick();
        tick();
        check("abort_dead4", observed(), enc(3));
        rst = 1'b1;
        tick();
        check("abort_rst_idle", observed(), enc(0));

        // Randomized run against the reference model.
        set_in(1'b1, 1'b1, 20, 20);
        tick();
        rst = 1'b0;
        ts = 20;
        ta = 20;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                ts = $urandom_range(0, 255);
                if ($urandom_range(0, 1) == 0) ta = $urandom_range(0, 255);
                else ta = ts + int'($urandom_range(0, 20)) - 10;
                if (ta < 0) ta = 0;
                if (ta > 255) ta = 255;
            end
            set_in($urandom_range(0, 199) == 0, $urandom_range(0, 29) != 0, ts, ta);
            tick();
            check("rand_outputs", observed(), enc(m_mode));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
